// File: rtl/fp32_to_int32.sv
// fp32_to_int32: multi-cycle IEEE-754 single to signed int32 converter, round-to-nearest-even
module fp32_to_int32 #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, OUT = 2'd3;
    logic [1:0]  state;
    logic        held, left, guard, sticky, s, exact, big;
    logic [31:0] op, acc, mask, mag;
    logic [4:0]  rem, sh, n;
    logic [7:0]  e;
    logic [23:0] m;
    assign in_ready  = state == IDLE && !held;
    assign out_valid = state == OUT;
    // unpack the latched operand, size the next shift step and form the rounded magnitude
    always_comb begin
        s     = op[31];
        e     = op[30:23];
        m     = {e != 8'd0, op[22:0]};
        n     = (e >= 8'd150) ? 5'(e - 8'd150) : 5'(8'd150 - e);
        exact = s && e == 8'd158 && op[22:0] == 23'd0;
        big   = e >= 8'd158 && !exact;
        sh    = (rem < 5'(STEP)) ? rem : 5'(STEP);
        mask  = (32'd1 << sh) - 32'd1;
        mag   = acc + {31'd0, guard & (sticky | acc[0])};
    end
    // capture, classify, denormalize, round and hold the result until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held        <= 1'b0;
            op          <= '0;
            acc         <= '0;
            rem         <= '0;
            left        <= 1'b0;
            guard       <= 1'b0;
            sticky      <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (held) begin
                    held   <= 1'b0;
                    acc    <= {8'd0, m};
                    rem    <= n;
                    left   <= e >= 8'd150;
                    guard  <= 1'b0;
                    sticky <= 1'b0;
                    if (e == 8'd255 && op[22:0] != 23'd0) begin
                        out_data    <= 32'h7FFF_FFFF;
                        out_invalid <= 1'b1;
                        out_inexact <= 1'b0;
                        state       <= OUT;
                    end else if (big) begin
                        out_data    <= s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        out_invalid <= 1'b1;
                        out_inexact <= 1'b0;
                        state       <= OUT;
                    end else if (exact) begin
                        out_data    <= 32'h8000_0000;
                        out_invalid <= 1'b0;
                        out_inexact <= 1'b0;
                        state       <= OUT;
                    end else if (e < 8'd126) begin
                        out_data    <= '0;
                        out_invalid <= 1'b0;
                        out_inexact <= |op[30:0];
                        state       <= OUT;
                    end else begin
                        state <= (n == 5'd0) ? ROUND : SHIFT;
                    end
                end else if (in_valid) begin
                    op   <= in_data;
                    held <= 1'b1;
                end
                SHIFT: begin
                    acc <= left ? acc << sh : acc >> sh;
                    if (!left) begin
                        guard  <= |(acc & (32'd1 << (sh - 5'd1)));
                        sticky <= sticky | guard | (|(acc & (mask >> 1)));
                    end
                    rem <= rem - sh;
                    if (rem == sh) state <= ROUND;
                end
                ROUND: begin
                    out_data    <= s ? -mag : mag;
                    out_invalid <= 1'b0;
                    out_inexact <= guard | sticky;
                    state       <= OUT;
                end
                OUT: if (out_ready) begin
                    out_invalid <= 1'b0;
                    out_inexact <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_to_int32.sv
// tb_fp32_to_int32: directed scoreboard bench for the FP32 to int32 converter
module tb_fp32_to_int32;
    typedef struct packed {
        logic [31:0] d;
        logic        inv;
        logic        inx;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_invalid, out_inexact;
    logic [31:0] in_data, out_data;
    logic        v8, rdy8, ov8, inv8, inx8;
    logic [31:0] od8;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    fp32_to_int32 #(.STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_invalid(out_invalid), .out_inexact(out_inexact)
    );
    fp32_to_int32 #(.STEP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(in_data),
        .out_valid(ov8), .out_ready(1'b1), .out_data(od8),
        .out_invalid(inv8), .out_inexact(inx8)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask
    task automatic conv(input logic [31:0] x, input logic [31:0] d, input logic inv, input logic inx,
                        input int lat, input int hold);
        exp_t e;
        int   cyc;
        q.push_back('{d, inv, inx, lat});
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        e = q.pop_front();
        check($sformatf("%h latency", x), cyc, e.lat);
        check($sformatf("%h data", x), out_data, e.d);
        check($sformatf("%h flags", x), {out_invalid, out_inexact}, {e.inv, e.inx});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = $urandom;
            @(posedge clk);
            #1 check($sformatf("%h held out", x), {out_valid, in_ready, out_invalid, out_inexact, out_data},
                     {1'b1, 1'b0, e.inv, e.inx, e.d});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check($sformatf("%h after transfer", x), {out_valid, in_ready, out_invalid, out_inexact}, 4'b0100);
    endtask
    task automatic conv8(input logic [31:0] x, input logic [31:0] d, input logic inx, input int lat);
        int cyc;
        @(negedge clk);
        in_data = x;
        v8      = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check($sformatf("step8 %h latency", x), cyc, lat);
        check($sformatf("step8 %h result", x), {inv8, inx8, od8}, {1'b0, inx, d});
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        v8        = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset state", {out_valid, in_ready, out_invalid, out_inexact, out_data}, {4'b0100, 32'd0});
        conv(32'h3FC0_0000, 32'd2,          1'b0, 1'b1, 25, 0);
        conv(32'h4020_0000, 32'd2,          1'b0, 1'b1, 24, 0);
        conv(32'hC060_0000, 32'hFFFF_FFFC,  1'b0, 1'b1, 24, 0);
        conv(32'hBFC0_0000, 32'hFFFF_FFFE,  1'b0, 1'b1, 25, 0);
        conv(32'h3F80_0000, 32'd1,          1'b0, 1'b0, 25, 0);
        conv(32'h4EFF_FFFF, 32'h7FFF_FF80,  1'b0, 1'b0, 9,  0);
        conv(32'hCF00_0000, 32'h8000_0000,  1'b0, 1'b0, 1,  0);
        conv(32'h4F00_0000, 32'h7FFF_FFFF,  1'b1, 1'b0, 1,  0);
        conv(32'hFF80_0000, 32'h8000_0000,  1'b1, 1'b0, 1,  0);
        conv(32'h7FC0_0000, 32'h7FFF_FFFF,  1'b1, 1'b0, 1,  0);
        conv(32'h3F00_0000, 32'd0,          1'b0, 1'b1, 26, 0);
        conv(32'h3F00_0001, 32'd1,          1'b0, 1'b1, 26, 0);
        conv(32'h8000_0000, 32'd0,          1'b0, 1'b0, 1,  0);
        conv(32'h0000_0001, 32'd0,          1'b0, 1'b1, 1,  0);
        conv(32'hC060_0000, 32'hFFFF_FFFC,  1'b0, 1'b1, 24, 5);
        conv(32'h4040_0000, 32'd3,          1'b0, 1'b0, 24, 0);
        conv8(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 3);
        conv8(32'h3FC0_0000, 32'd2,         1'b1, 5);
        conv8(32'h3F00_0001, 32'd1,         1'b1, 5);
        @(negedge clk);
        in_data  = 32'h3FC0_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset mid-shift", {out_valid, in_ready, out_data}, {2'b01, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        conv(32'h4040_0000, 32'd3, 1'b0, 1'b0, 24, 0);
        check("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp32_to_int32.md
Name: fp32_to_int32

Overview:
- Multi-cycle converter from an IEEE-754 single-precision value to a signed 32-bit two's-complement integer, rounding to nearest-even.
- It is the inverse of the FP adder's normalize/pack stage: it unpacks sign, exponent and mantissa, denormalizes with an iterative shifter, then rounds and re-applies the sign.
- It sits downstream of the FP adder and feeds integer consumers through valid/ready handshakes on both sides.

Parameters:
- STEP, 1, number of bit positions shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in state IDLE.
- in_data  input  32  FP32 operand: [31] sign, [30:23] exponent, [22:0] fraction.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  signed int32 result.
- out_invalid  output  1  NaN, infinity or out-of-range input; out_data is saturated.
- out_inexact  output  1  result differs from the exact input value.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_data=0; out_invalid=0; out_inexact=0; in_ready=1.
  - A reset asserted mid-conversion abandons the operation immediately and emits no result.
- States: IDLE, SHIFT, ROUND, OUT.
- Capture: in IDLE, in_valid&&in_ready at edge k latches s=in_data[31], e=in_data[30:23], f=in_data[22:0].
  - Significand m = {(e!=0), f}, 24 bits.
  - Unbiased exponent E = e-127, signed 9-bit arithmetic.
- Special cases go IDLE->OUT, with out_valid=1 after edge k+1:
  - e==255, f!=0 (NaN): out_data=0x7FFFFFFF, invalid=1.
  - e==255, f==0 (infinity): out_data=0x7FFFFFFF if s=0 else 0x80000000; invalid=1.
  - e>=158, excluding the exact case s=1, e=158, f=0: saturate as for infinity; invalid=1.
  - Exact case s=1, e=158, f=0: out_data=0x80000000, invalid=0, inexact=0.
  - e<126, including zero and subnormals: out_data=0; inexact=(e!=0 || f!=0); sign is ignored, so -0 gives 0.
- Normal path (126<=e<=157), shift amount n:
  - E>=23: left shift by n=E-23 (0..7).
  - E<23: right shift by n=23-E (1..24).
- SHIFT state:
  - Each cycle shifts the accumulator by min(STEP, remaining) and decrements remaining.
  - Right shifts: guard = most recent bit shifted out; sticky |= OR of all earlier shifted-out bits.
  - Left shifts leave guard=sticky=0.
  - If n==0, SHIFT is skipped and the block goes straight to ROUND.
  - The remaining-count register is 5 bits wide.
- ROUND state (one cycle):
  - mag += guard && (sticky || mag[0]).
  - inexact = guard | sticky.
  - out_data = s ? -mag : mag.
  - The rounded magnitude cannot exceed 2^31-1 on this path.
- Latency:
  - Normal: out_valid rises after edge k+1+ceil(n/STEP)+1.
  - Special: out_valid rises after edge k+1.
- OUT state:
  - out_valid=1; out_data and flags stay stable while out_ready=0.
  - The out_valid&&out_ready edge moves to IDLE: out_valid=0, in_ready=1 the following cycle.
  - No accept occurs in the same cycle as a result transfer; throughput is one conversion per (latency+1) cycles minimum.
- in_data is ignored outside IDLE.
- Flags are valid only while out_valid=1; they clear to 0 on the transfer edge.

Test Plan:
- 1.5 and 2.5 (STEP=1): 0x3FC00000 -> out_data=2, inexact=1, invalid=0, out_valid rises after edge k+25 (n=23). 0x40200000 (2.5) -> 2, inexact=1 (ties to even).
- Negative and exact values: 0xC0600000 (-3.5) -> 0xFFFFFFFC, inexact=1. 0x4EFFFFFF -> 0x7FFFFF80, inexact=0; at STEP=1 (n=7 left) out_valid after edge k+9, at STEP=8 after edge k+3.
- Range limits: 0xCF000000 -> 0x80000000, invalid=0. 0x4F000000 -> 0x7FFFFFFF, invalid=1. 0xFF800000 -> 0x80000000, invalid=1. 0x7FC00000 -> 0x7FFFFFFF, invalid=1; each special case has out_valid after edge k+1.
- Small values: 0x3F000000 (0.5) -> 0, inexact=1. 0x3F000001 -> 1, inexact=1. 0x80000000 -> 0, inexact=0. 0x00000001 -> 0, inexact=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while toggling in_valid with new data -> out_data and flags stable, in_ready=0, new data ignored. Raise out_ready -> one transfer, in_ready=1 the next cycle.
- Reset mid-SHIFT: assert rst_n=0 during SHIFT of 0x3FC00000 -> out_valid=0, out_data=0 and in_ready=1 asynchronously. After release, 0x40400000 converts to 3 with no residue from the aborted operation.
